uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Next-generation UART transmitter with runtime-configurable frames: 5..DataWidth data bits, none/even/odd/mark/space parity, and 1 or 2 stop bits. It takes words through a valid/ready handshake into a single-entry holding register, so frames can be sent back-to-back with no idle gap. Bit timing comes from an external baud tick (txClk of the baud generator) on `en`. It sits between the AHB UART register block and the TX pin.

Parameters:
DataWidth, 8, maximum data bits per frame; legal range 5..16.
LenWidth, $clog2(DataWidth+1), width of dataLen; derived, never overridden.
BreakLen, 13, minimum break length in baud ticks; used only with UART_TX_BREAK_EN.

Ports:
clk  in  1  single clock; all state changes on its rising edge.
syncReset  in  1  reset: synchronous and active-high.
en  in  1  baud tick; one-cycle pulse per bit period.
data  in  DataWidth  word to send; LSB is transmitted first.
dataLen  in  LenWidth  data bits per frame; values <5 clamp to 5, values >DataWidth clamp to DataWidth.
parityMode  in  3  0 none, 1 even, 2 odd, 3 mark (1), 4 space (0), 5..7 treated as none.
stopBits  in  1  0 = one stop bit, 1 = two stop bits.
valid  in  1  data/config offered.
ready  out  1  holding register empty.
out  out  1  serial line; idles at 1.
busy  out  1  1 whenever state != IDLE.
done  out  1  one-clk pulse when the last stop bit ends.

Behaviour:
- Reset values: out=1, ready=1, busy=0, done=0, state=IDLE, holding register empty. Reset mid-frame abandons the frame: out returns to 1 on the next cycle and done does not pulse.
- Handshake: a transfer occurs when valid && ready on any clk edge, independent of `en`. data, clamped length, parityMode and stopBits are latched together into the holding register. ready falls on the next cycle.
- Config is frozen per frame. Input changes after acceptance have no effect on that frame.
- States: IDLE, START, DATA, PARITY, STOP (plus BREAK under the macro). Transitions happen only on cycles with en=1, so each state lasts exactly one tick, except DATA (len ticks) and STOP (1 or 2 ticks).
- IDLE -> START: on en with the holding register full. In the same cycle the holding register moves into the shift register and empties; ready=1 from the next cycle.
- START: out=0. START -> DATA.
- DATA: out = shift[0]; shift right on each tick; bit counter counts down from len. After len ticks: -> PARITY if parity is enabled, else -> STOP.
- PARITY: out = even: XOR of the len data bits; odd: its inverse; mark: 1; space: 0. Only the len low bits participate. PARITY -> STOP.
- STOP: out=1 for 1 or 2 ticks. On the tick that ends STOP, done=1 for that clk cycle. Then -> START if the holding register is full (back-to-back, zero gap), else -> IDLE.
- out is registered. It changes only on the clk edge that follows an en cycle, or on reset.
- en held at 1 every cycle is legal: one bit per clk.

Optional Feature:
Macro UART_TX_BREAK_EN.
- With the macro: adds input sendBreak (1 bit) and state BREAK.
- From IDLE on en with sendBreak=1 (priority over pending data): -> BREAK, out=0.
- BREAK lasts at least BreakLen ticks and continues while sendBreak=1. It then takes one STOP tick (out=1, no done pulse) -> IDLE.
- valid/ready operate normally during BREAK.
- Without the macro: the port, the state and the BreakLen logic are absent, and behaviour is identical to the above.

Decomposition:
- Package uart_pkg: parity_t enum (NONE, EVEN, ODD, MARK, SPACE); tx_state_t enum; MIN_DATA_BITS=5; the length clamp function.
- One natural sub-module: uart_tx_holding. It is the single-entry valid/ready register holding {data, len, parity, stop}, with a pop input from the FSM.
- FSM, shift register and parity generator stay in uart_tx_frame.

Test Plan:
- en every cycle, len=8, parity none, 1 stop, data=0x55 -> out 0,1,0,1,0,1,0,1,0,1 then idle 1; done pulses once on the 10th tick.
- len=7, odd parity, 2 stop, data=0x07 -> out 0,1,1,1,0,0,0,0,0,1,1 (11 ticks); done once.
- valid held with 0xA5 then 0x3C, en every 4 clks -> second word accepted during the first frame's START; no idle tick between the first STOP and the second START; two done pulses.
- DataWidth=9, dataLen=15, even parity, data=0x1FF -> 9 data 1s, parity=1; dataLen=3 with data=0x1F -> 5 data bits sent.
- syncReset asserted mid-DATA -> next cycle out=1, busy=0, ready=1, no done; a config change mid-frame leaves the current frame unaltered.
- With UART_TX_BREAK_EN, sendBreak high for 3 ticks -> out=0 for exactly 13 ticks, then 1 tick of 1, then IDLE; a pending word is sent afterwards.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: parity modes, FSM state
// encodings and the data-length clamp.
package uart_pkg;

   localparam int unsigned MIN_DATA_BITS = 5;

   typedef enum logic [2:0] {
      PAR_NONE  = 3'd0,
      PAR_EVEN  = 3'd1,
      PAR_ODD   = 3'd2,
      PAR_MARK  = 3'd3,
      PAR_SPACE = 3'd4
   } parity_t;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_BREAK  = 3'd5;

   typedef enum logic [2:0] {
      TX_IDLE   = ST_IDLE,
      TX_START  = ST_START,
      TX_DATA   = ST_DATA,
      TX_PARITY = ST_PARITY,
      TX_STOP   = ST_STOP,
      TX_BREAK  = ST_BREAK
   } tx_state_t;

   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
      if (len < MIN_DATA_BITS) return MIN_DATA_BITS;
      if (len > max_len) return max_len;
      return len;
   endfunction

   function automatic parity_t decode_parity(input logic [2:0] mode);
      case (mode)
         3'd1:    return PAR_EVEN;
         3'd2:    return PAR_ODD;
         3'd3:    return PAR_MARK;
         3'd4:    return PAR_SPACE;
         default: return PAR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_holding.sv
// Single-entry holding register for one frame's data and configuration;
// filled through valid/ready, emptied by a pop from the transmit FSM.
module uart_tx_holding import uart_pkg::*; #(
   parameter int DataWidth = 8,
   parameter int LenWidth  = 4
) (
   input  logic                 clk,
   input  logic                 syncReset,
   input  logic                 push_valid_i,
   input  logic [DataWidth-1:0] data_i,
   input  logic [LenWidth-1:0]  len_i,
   input  parity_t              parity_i,
   input  logic                 stop2_i,
   input  logic                 pop_i,
   output logic                 ready_o,
   output logic                 full_o,
   output logic [DataWidth-1:0] data_o,
   output logic [LenWidth-1:0]  len_o,
   output parity_t              parity_o,
   output logic                 stop2_o
);

   logic                 full_q;
   logic [DataWidth-1:0] data_q;
   logic [LenWidth-1:0]  len_q;
   parity_t              parity_q;
   logic                 stop2_q;
   logic                 push;

   assign push = push_valid_i && !full_q;

   always_ff @(posedge clk) begin
      if (syncReset) begin
         full_q <= 1'b0;
      end else if (push) begin
         full_q <= 1'b1;
      end else if (pop_i) begin
         full_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_q   <= data_i;
         len_q    <= len_i;
         parity_q <= parity_i;
         stop2_q  <= stop2_i;
      end
   end

   assign ready_o  = !full_q;
   assign full_o   = full_q;
   assign data_o   = data_q;
   assign len_o    = len_q;
   assign parity_o = parity_q;
   assign stop2_o  = stop2_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with per-frame length, parity and stop-bit configuration.
// Optional line-break generation is enabled with UART_TX_BREAK_EN.
//   state  | meaning
//   IDLE   | line high, waiting for a word (or a break request)
//   START  | start bit (0)
//   DATA   | len data bits, LSB first
//   PARITY | parity bit
//   STOP   | 1 or 2 stop bits; done pulses on the last tick
//   BREAK  | line held low for at least BreakLen ticks
module uart_tx_frame import uart_pkg::*; #(
   parameter int  DataWidth = 8,
   parameter int  BreakLen  = 13,
   localparam int LenWidth  = $clog2(DataWidth + 1)
) (
   input  logic                 clk,
   input  logic                 syncReset,
   input  logic                 en,
   input  logic [DataWidth-1:0] data,
   input  logic [LenWidth-1:0]  dataLen,
   input  logic [2:0]           parityMode,
   input  logic                 stopBits,
   input  logic                 valid,
`ifdef UART_TX_BREAK_EN
   input  logic                 sendBreak,
`endif
   output logic                 ready,
   output logic                 out,
   output logic                 busy,
   output logic                 done
);

   if (DataWidth < MIN_DATA_BITS || DataWidth > 16 || BreakLen < 1) begin : g_param_check
      $error("uart_tx_frame: DataWidth must be 5..16 and BreakLen >= 1");
   end

   logic                 hold_full;
   logic [DataWidth-1:0] hold_data;
   logic [LenWidth-1:0]  hold_len;
   logic [LenWidth-1:0]  len_clamped;
   parity_t              hold_parity;
   logic                 hold_stop2;
   logic                 start_frame;

   assign len_clamped = LenWidth'(clamp_len(32'(dataLen), DataWidth));

   uart_tx_holding #(
      .DataWidth (DataWidth),
      .LenWidth  (LenWidth)
   ) u_holding (
      .clk          (clk),
      .syncReset    (syncReset),
      .push_valid_i (valid),
      .data_i       (data),
      .len_i        (len_clamped),
      .parity_i     (decode_parity(parityMode)),
      .stop2_i      (stopBits),
      .pop_i        (start_frame),
      .ready_o      (ready),
      .full_o       (hold_full),
      .data_o       (hold_data),
      .len_o        (hold_len),
      .parity_o     (hold_parity),
      .stop2_o      (hold_stop2)
   );

   tx_state_t            state_q, state_d;
   logic [DataWidth-1:0] shift_q, shift_d;
   logic [LenWidth-1:0]  bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic                 stop2_q, stop2_d;
   logic                 par_en_q, par_en_d;
   logic                 par_bit_q, par_bit_d;
   logic                 out_q, out_d;
   logic [DataWidth-1:0] par_mask;
   logic                 load_par_bit;
   logic                 stop_is_break;

`ifdef UART_TX_BREAK_EN
   localparam int BrkWidth = $clog2(BreakLen + 1);
   logic [BrkWidth-1:0] brk_cnt_q, brk_cnt_d;
   logic                brk_stop_q, brk_stop_d;
   assign stop_is_break = brk_stop_q;
`else
   assign stop_is_break = 1'b0;
`endif

   // Parity covers only the configured number of low data bits.
   always_comb begin
      par_mask = '0;
      for (int i = 0; i < DataWidth; i++) par_mask[i] = (i < int'(hold_len));
      case (hold_parity)
         PAR_EVEN: load_par_bit = ^(hold_data & par_mask);
         PAR_ODD:  load_par_bit = ~^(hold_data & par_mask);
         PAR_MARK: load_par_bit = 1'b1;
         default:  load_par_bit = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      stop2_d     = stop2_q;
      par_en_d    = par_en_q;
      par_bit_d   = par_bit_q;
      out_d       = out_q;
      start_frame = 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt_d   = brk_cnt_q;
      brk_stop_d  = brk_stop_q;
`endif
      if (en) begin
         case (state_q)
            TX_IDLE: begin
`ifdef UART_TX_BREAK_EN
               if (sendBreak) begin
                  state_d   = TX_BREAK;
                  out_d     = 1'b0;
                  brk_cnt_d = BrkWidth'(BreakLen - 1);
               end else
`endif
               if (hold_full) start_frame = 1'b1;
            end
            TX_START: begin
               state_d = TX_DATA;
               out_d   = shift_q[0];
               shift_d = shift_q >> 1;
            end
            TX_DATA: begin
               if (bit_cnt_q != '0) begin
                  out_d     = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q - LenWidth'(1);
               end else if (par_en_q) begin
                  state_d = TX_PARITY;
                  out_d   = par_bit_q;
               end else begin
                  state_d    = TX_STOP;
                  out_d      = 1'b1;
                  stop_cnt_d = stop2_q;
               end
            end
            TX_PARITY: begin
               state_d    = TX_STOP;
               out_d      = 1'b1;
               stop_cnt_d = stop2_q;
            end
            TX_STOP: begin
               if (stop_cnt_q) begin
                  stop_cnt_d = 1'b0;
               end else begin
`ifdef UART_TX_BREAK_EN
                  brk_stop_d = 1'b0;
`endif
                  // Back-to-back frames skip IDLE; a break always returns to IDLE.
                  if (hold_full && !stop_is_break) begin
                     start_frame = 1'b1;
                  end else begin
                     state_d = TX_IDLE;
                     out_d   = 1'b1;
                  end
               end
            end
`ifdef UART_TX_BREAK_EN
            TX_BREAK: begin
               if (brk_cnt_q != '0) begin
                  brk_cnt_d = brk_cnt_q - BrkWidth'(1);
               end else if (!sendBreak) begin
                  state_d    = TX_STOP;
                  out_d      = 1'b1;
                  stop_cnt_d = 1'b0;
                  brk_stop_d = 1'b1;
               end
            end
`endif
            default: begin
               state_d = TX_IDLE;
               out_d   = 1'b1;
            end
         endcase
      end
      if (start_frame) begin
         state_d   = TX_START;
         out_d     = 1'b0;
         shift_d   = hold_data;
         bit_cnt_d = hold_len - LenWidth'(1);
         stop2_d   = hold_stop2;
         par_en_d  = (hold_parity != PAR_NONE);
         par_bit_d = load_par_bit;
      end
   end

   always_ff @(posedge clk) begin
      if (syncReset) begin
         state_q    <= TX_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         stop2_q    <= 1'b0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         out_q      <= 1'b1;
`ifdef UART_TX_BREAK_EN
         brk_cnt_q  <= '0;
         brk_stop_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         stop2_q    <= stop2_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         out_q      <= out_d;
`ifdef UART_TX_BREAK_EN
         brk_cnt_q  <= brk_cnt_d;
         brk_stop_q <= brk_stop_d;
`endif
      end
   end

   assign out  = out_q;
   assign busy = (state_q != TX_IDLE);
   assign done = en && !syncReset && (state_q == TX_STOP) && !stop_cnt_q && !stop_is_break;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8-bit and 9-bit instances, line bits
// compared against hand-built frame patterns (break test with UART_TX_BREAK_EN).
module tb_uart_tx_frame;

   logic       clk = 1'b0;
   logic       syncReset, en;
   logic [7:0] data8;
   logic [8:0] data9;
   logic [3:0] dataLen;
   logic [2:0] parityMode;
   logic       stopBits, valid8, valid9;
   logic       ready8, out8, busy8, done8;
   logic       ready9, out9, busy9, done9;
`ifdef UART_TX_BREAK_EN
   logic       sendBreak;
`endif

   int          n_assert, n_fail, en_period, cyc, done_cnt, nacc, ridx;
   logic        last_en, acc, recording;
   logic [31:0] rec;

   always #5 clk = ~clk;

   uart_tx_frame u_dut8 (
      .clk(clk), .syncReset(syncReset), .en(en), .data(data8), .dataLen(dataLen),
      .parityMode(parityMode), .stopBits(stopBits), .valid(valid8),
`ifdef UART_TX_BREAK_EN
      .sendBreak(sendBreak),
`endif
      .ready(ready8), .out(out8), .busy(busy8), .done(done8)
   );

   uart_tx_frame #(.DataWidth(9)) u_dut9 (
      .clk(clk), .syncReset(syncReset), .en(en), .data(data9), .dataLen(dataLen),
      .parityMode(parityMode), .stopBits(stopBits), .valid(valid9),
`ifdef UART_TX_BREAK_EN
      .sendBreak(1'b0),
`endif
      .ready(ready9), .out(out9), .busy(busy9), .done(done9)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next negedge, then choose en for the following posedge.
   task automatic step();
      last_en = en;
      @(negedge clk);
      cyc++;
      en = (en_period == 0) ? 1'b0 : ((en_period == 1) ? 1'b1 : ((cyc % en_period) == 0));
      #1;
      if (done8 === 1'b1 || done9 === 1'b1) done_cnt++;
   endtask

   task automatic send(input bit sel9, input logic [15:0] d, input logic [3:0] len,
                       input logic [2:0] pm, input logic sb);
      data8 = d[7:0];
      data9 = d[8:0];
      dataLen = len;
      parityMode = pm;
      stopBits = sb;
      if (sel9) valid9 = 1'b1; else valid8 = 1'b1;
      step();
      valid8 = 1'b0;
      valid9 = 1'b0;
      chk("ready low after accept", 32'(sel9 ? ready9 : ready8), 32'd0);
   endtask

   task automatic frame_check(input string tag, input bit sel9, input logic [31:0] exp, input int n);
      for (int i = 0; i < n; i++) begin
         step();
         chk($sformatf("%s line bit %0d", tag, i), 32'(sel9 ? out9 : out8), 32'(exp[i]));
         chk($sformatf("%s done at %0d", tag, i), 32'(sel9 ? done9 : done8), 32'(i == n - 1));
         if (i == 0) begin
            chk($sformatf("%s ready after load", tag), 32'(sel9 ? ready9 : ready8), 32'd1);
            chk($sformatf("%s busy in frame", tag), 32'(sel9 ? busy9 : busy8), 32'd1);
         end
      end
      step();
      chk($sformatf("%s idle out", tag), 32'(sel9 ? out9 : out8), 32'd1);
      chk($sformatf("%s idle busy", tag), 32'(sel9 ? busy9 : busy8), 32'd0);
   endtask

   initial begin
      n_assert = 0; n_fail = 0; cyc = 0; en_period = 0; done_cnt = 0;
      en = 1'b0; syncReset = 1'b1; valid8 = 1'b0; valid9 = 1'b0;
      data8 = '0; data9 = '0; dataLen = 4'd8; parityMode = 3'd0; stopBits = 1'b0;
`ifdef UART_TX_BREAK_EN
      sendBreak = 1'b0;
`endif
      step();
      step();
      syncReset = 1'b0;
      chk("reset out", 32'(out8), 32'd1);
      chk("reset ready", 32'(ready8), 32'd1);
      chk("reset busy", 32'(busy8), 32'd0);
      chk("reset done", 32'(done8), 32'd0);

      // 8N1, 0x55
      en_period = 1; en = 1'b1;
      send(1'b0, 16'h0055, 4'd8, 3'd0, 1'b0);
      frame_check("8N1 0x55", 1'b0, 32'h2AA, 10);

      // 7 bits, odd parity, 2 stop, 0x07; inputs scrambled after acceptance
      send(1'b0, 16'h0007, 4'd7, 3'd2, 1'b1);
      data8 = 8'hFF; dataLen = 4'd3; parityMode = 3'd1; stopBits = 1'b0;
      frame_check("7O2 0x07", 1'b0, 32'h60E, 11);

      // 9-bit instance: length 15 clamps to 9, even parity over nine 1s
      send(1'b1, 16'h01FF, 4'd15, 3'd1, 1'b0);
      frame_check("9E1 0x1FF", 1'b1, 32'hFFE, 12);
      // length 3 clamps to 5, parity mode 5 behaves as none
      send(1'b1, 16'h001F, 4'd3, 3'd5, 1'b0);
      frame_check("len3 clamp", 1'b1, 32'h7E, 7);

      // Back-to-back with en every 4 clocks
      en_period = 4; en = 1'b0; done_cnt = 0; nacc = 0; ridx = 0; rec = '0; recording = 1'b0;
      data8 = 8'hA5; dataLen = 4'd8; parityMode = 3'd0; stopBits = 1'b0; valid8 = 1'b1;
      for (int c = 0; c < 400 && ridx < 21; c++) begin
         acc = valid8 && ready8;
         if (acc && nacc == 1) chk("second word accepted in START", 32'(ridx), 32'd1);
         step();
         if (acc) begin
            nacc++;
            if (nacc == 1) data8 = 8'h3C; else valid8 = 1'b0;
         end
         if (last_en && (recording || out8 === 1'b0)) begin
            recording = 1'b1;
            rec[ridx] = out8;
            ridx++;
         end
      end
      chk("b2b tick count", 32'(ridx), 32'd21);
      chk("b2b line bits", rec, 32'({1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}));
      chk("b2b done pulses", 32'(done_cnt), 32'd2);
      chk("b2b words accepted", 32'(nacc), 32'd2);

      // Reset in the middle of DATA with a second word pending
      en_period = 1; en = 1'b1; valid8 = 1'b0;
      repeat (3) step();
      send(1'b0, 16'h0000, 4'd8, 3'd0, 1'b0);
      data8 = 8'hFF; valid8 = 1'b1;
      step(); step(); step();
      valid8 = 1'b0;
      chk("pre-reset holding full", 32'(ready8), 32'd0);
      chk("pre-reset busy", 32'(busy8), 32'd1);
      chk("pre-reset data bit", 32'(out8), 32'd0);
      syncReset = 1'b1;
      done_cnt = 0;
      step();
      syncReset = 1'b0;
      chk("mid-frame reset out", 32'(out8), 32'd1);
      chk("mid-frame reset busy", 32'(busy8), 32'd0);
      chk("mid-frame reset ready", 32'(ready8), 32'd1);
      chk("mid-frame reset done", 32'(done8), 32'd0);
      repeat (12) step();
      chk("after reset no done", 32'(done_cnt), 32'd0);
      chk("after reset idle out", 32'(out8), 32'd1);
      chk("after reset idle busy", 32'(busy8), 32'd0);

`ifdef UART_TX_BREAK_EN
      // Word pending before the break; break wins, word follows afterwards
      en_period = 0; en = 1'b0;
      data8 = 8'h00; dataLen = 4'd8; parityMode = 3'd0; stopBits = 1'b0; valid8 = 1'b1;
      step();
      valid8 = 1'b0;
      chk("break pending word accepted", 32'(ready8), 32'd0);
      en_period = 1; en = 1'b1; sendBreak = 1'b1;
      done_cnt = 0; ridx = 0; rec = '0; recording = 1'b0;
      for (int c = 0; c < 80 && ridx < 25; c++) begin
         step();
         if (c == 2) sendBreak = 1'b0;
         if (recording || out8 === 1'b0) begin
            recording = 1'b1;
            rec[ridx] = out8;
            ridx++;
         end
      end
      chk("break tick count", 32'(ridx), 32'd25);
      chk("break line bits", rec, 32'({1'b1, 8'h00, 1'b0, 2'b11, 13'h0000}));
      chk("break done pulses", 32'(done_cnt), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish within bound");
      $fatal(1, "timeout");
   end

endmodule
